// File: rtl/haar_stage_sequencer.sv
// Walks the cascade database stage by stage (READ->WAIT->OUT, 3 cycles/word with ready high).
// OUT holds word and indices until i_data_ready; stage boundaries wait for the evaluator verdict.
module haar_stage_sequencer #(
  parameter int ADDR_WIDTH               = 10,
  parameter int DATA_WIDTH_12            = 12,
  parameter int NUM_STAGES               = 4,
  parameter int NUM_CLASSIFIERS_STAGE    = 10,
  parameter int NUM_PARAM_PER_CLASSIFIER = 19,
  parameter int NUM_STAGE_THRESHOLD      = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  output logic                     o_mem_ren,
  output logic [ADDR_WIDTH-1:0]    o_mem_addr,
  input  logic [DATA_WIDTH_12-1:0] i_mem_data,
  output logic [DATA_WIDTH_12-1:0] o_data,
  output logic                     o_data_valid,
  input  logic                     i_data_ready,
  output logic [DATA_WIDTH_12-1:0] o_index_stage,
  output logic [DATA_WIDTH_12-1:0] o_index_classifier,
  output logic [DATA_WIDTH_12-1:0] o_index_param,
  output logic                     o_is_threshold,
  output logic                     o_end_classifier,
  output logic                     o_end_stage,
  input  logic                     i_stage_result_valid,
  input  logic                     i_stage_pass,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_face_detected
);

  localparam int SIZE_STAGE = NUM_CLASSIFIERS_STAGE*NUM_PARAM_PER_CLASSIFIER + NUM_STAGE_THRESHOLD;

  localparam logic [DATA_WIDTH_12-1:0] LAST_STAGE = DATA_WIDTH_12'(NUM_STAGES-1);
  localparam logic [DATA_WIDTH_12-1:0] THR_CLS    = DATA_WIDTH_12'(NUM_CLASSIFIERS_STAGE);
  localparam logic [DATA_WIDTH_12-1:0] LAST_PARAM = DATA_WIDTH_12'(NUM_PARAM_PER_CLASSIFIER-1);
  localparam logic [DATA_WIDTH_12-1:0] LAST_THR   = DATA_WIDTH_12'(NUM_STAGE_THRESHOLD-1);
  localparam logic [ADDR_WIDTH-1:0]    STAGE_STEP = ADDR_WIDTH'(SIZE_STAGE);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_OUT, S_VERDICT, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]    base_q, base_d;
  logic [ADDR_WIDTH-1:0]    offset_q, offset_d;
  logic [DATA_WIDTH_12-1:0] data_q, data_d;
  logic [DATA_WIDTH_12-1:0] stage_q, stage_d;
  logic [DATA_WIDTH_12-1:0] cls_q, cls_d;
  logic [DATA_WIDTH_12-1:0] param_q, param_d;
  logic                     face_q, face_d;
  logic                     load_addr;
  logic                     is_thr;
  logic                     last_word;

  assign is_thr    = (cls_q == THR_CLS);
  assign last_word = is_thr && (param_q == LAST_THR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      base_q   <= '0;
      offset_q <= '0;
      data_q   <= '0;
      stage_q  <= '0;
      cls_q    <= '0;
      param_q  <= '0;
      face_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      base_q   <= base_d;
      offset_q <= offset_d;
      data_q   <= data_d;
      stage_q  <= stage_d;
      cls_q    <= cls_d;
      param_q  <= param_d;
      face_q   <= face_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    offset_d  = offset_q;
    data_d    = data_q;
    stage_d   = stage_q;
    cls_d     = cls_q;
    param_d   = param_q;
    face_d    = face_q;
    load_addr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d   = S_READ;
          base_d    = '0;
          offset_d  = '0;
          stage_d   = '0;
          cls_d     = '0;
          param_d   = '0;
          face_d    = 1'b0;
          load_addr = 1'b1;
        end
      end
      S_READ: state_d = S_WAIT;
      S_WAIT: begin
        data_d  = i_mem_data;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (i_data_ready) begin
          if (last_word) begin
            state_d = S_VERDICT;
          end else begin
            // offset tracks classifier*NUM_PARAM_PER_CLASSIFIER + param incrementally
            state_d   = S_READ;
            offset_d  = offset_q + 1'b1;
            load_addr = 1'b1;
            if (!is_thr && (param_q == LAST_PARAM)) begin
              param_d = '0;
              cls_d   = cls_q + 1'b1;
            end else begin
              param_d = param_q + 1'b1;
            end
          end
        end
      end
      S_VERDICT: begin
        if (i_stage_result_valid) begin
          if (!i_stage_pass) begin
            state_d = S_DONE;
            face_d  = 1'b0;
          end else if (stage_q == LAST_STAGE) begin
            state_d = S_DONE;
            face_d  = 1'b1;
          end else begin
            state_d   = S_READ;
            base_d    = base_q + STAGE_STEP;
            stage_d   = stage_q + 1'b1;
            cls_d     = '0;
            param_d   = '0;
            offset_d  = '0;
            load_addr = 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The address register only moves when a read is about to be issued.
  assign addr_d = load_addr ? (base_d + offset_d) : addr_q;

  always_comb begin
    o_mem_ren    = 1'b0;
    o_data_valid = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (state_q)
      S_READ: begin
        o_mem_ren = 1'b1;
        o_busy    = 1'b1;
      end
      S_WAIT, S_VERDICT: o_busy = 1'b1;
      S_OUT: begin
        o_data_valid = 1'b1;
        o_busy       = 1'b1;
      end
      S_DONE:  o_done = 1'b1;
      default: ;
    endcase
  end

  assign o_mem_addr         = addr_q;
  assign o_data             = data_q;
  assign o_index_stage      = stage_q;
  assign o_index_classifier = cls_q;
  assign o_index_param      = param_q;
  assign o_face_detected    = face_q;
  assign o_is_threshold     = o_data_valid && is_thr;
  assign o_end_classifier   = o_data_valid && !is_thr && (param_q == LAST_PARAM);
  assign o_end_stage        = o_data_valid && last_word;

endmodule

// File: doc/haar_stage_sequencer.md
Name: haar_stage_sequencer

Overview:
- Controller that walks the cascade database in stage memory, stage by stage.
- Per stage: issues reads for every classifier parameter word, then the stage-threshold words, tagging each with stage/classifier/parameter indices.
- Hands each word to the classifier datapath through a valid/ready handshake.
- Waits for the stage evaluator's pass/fail verdict, then advances to the next stage, or terminates the window early with a face/no-face result.

Parameters:
- ADDR_WIDTH, 10: stage memory address width.
- DATA_WIDTH_12, 12: data word and index width.
- NUM_STAGES, 4: stages in the cascade.
- NUM_CLASSIFIERS_STAGE, 10: classifiers per stage.
- NUM_PARAM_PER_CLASSIFIER, 19: words per classifier.
- NUM_STAGE_THRESHOLD, 3: threshold words appended after the classifiers of each stage.
- Derived (localparam) SIZE_STAGE = NUM_CLASSIFIERS_STAGE*NUM_PARAM_PER_CLASSIFIER + NUM_STAGE_THRESHOLD.

Ports:
- clk, input, 1: single clock.
- reset, input, 1: synchronous, active-high reset.
- i_start, input, 1: one-cycle pulse to begin evaluating a window; ignored unless idle.
- o_mem_ren, output, 1: stage memory read enable.
- o_mem_addr, output, ADDR_WIDTH: stage memory read address.
- i_mem_data, input, DATA_WIDTH_12: memory read data, valid exactly 1 cycle after o_mem_ren.
- o_data, output, DATA_WIDTH_12: current database word.
- o_data_valid, output, 1: o_data and all indices are valid.
- i_data_ready, input, 1: consumer accepts the word when high with o_data_valid.
- o_index_stage, output, DATA_WIDTH_12: current stage, 0..NUM_STAGES-1.
- o_index_classifier, output, DATA_WIDTH_12: classifier 0..NUM_CLASSIFIERS_STAGE-1; equals NUM_CLASSIFIERS_STAGE during threshold words.
- o_index_param, output, DATA_WIDTH_12: word within classifier, or within the threshold block.
- o_is_threshold, output, 1: current word is a stage-threshold word.
- o_end_classifier, output, 1: current word is the last parameter of a classifier.
- o_end_stage, output, 1: current word is the last word of the stage.
- i_stage_result_valid, input, 1: stage verdict strobe.
- i_stage_pass, input, 1: verdict; sampled only with i_stage_result_valid.
- o_busy, output, 1: high from accepted start until done.
- o_done, output, 1: one-cycle pulse at end of window.
- o_face_detected, output, 1: window result; held until the next accepted i_start.

Behaviour:
- Reset (synchronous): state IDLE; all outputs 0, including indices, o_mem_addr, o_face_detected; stage base address register 0.
- State IDLE:
  - i_start → READ; clear indices and stage base; clear o_face_detected; assert o_busy.
- State READ:
  - Drive o_mem_ren=1, o_mem_addr = stage_base + offset for one cycle → WAIT.
  - offset = classifier*NUM_PARAM_PER_CLASSIFIER + param, kept as a running counter; no multiplier.
- State WAIT:
  - Capture i_mem_data into o_data; assert o_data_valid → OUT.
- State OUT:
  - Hold o_data, o_data_valid and indices stable until i_data_ready=1.
  - On acceptance, drop valid and advance counters:
    - param wraps at NUM_PARAM_PER_CLASSIFIER-1 and increments classifier.
    - When classifier reaches NUM_CLASSIFIERS_STAGE, enter the threshold block: param runs 0..NUM_STAGE_THRESHOLD-1 with o_is_threshold=1.
  - Not end of stage → READ. End of stage → VERDICT.
- State VERDICT:
  - Wait for i_stage_result_valid.
  - Fail → DONE, face=0.
  - Pass on stage < NUM_STAGES-1 → stage_base += SIZE_STAGE, stage+1, classifier/param/offset cleared → READ.
  - Pass on last stage → DONE, face=1.
- State DONE:
  - o_done=1 for one cycle; o_busy=0 → IDLE.
- Throughput: 3 cycles per word with ready held high.
  - First o_mem_ren is the cycle after the start is accepted.
  - First o_data_valid is 2 cycles after o_mem_ren.
- o_end_classifier and o_end_stage are combinational from the current indices and qualified by o_data_valid.
- Handshake and verdict corner cases:
  - i_data_ready while o_data_valid=0: no effect.
  - i_stage_result_valid outside VERDICT: ignored.
  - i_start while busy: ignored.
- Reset mid-operation: abort immediately to IDLE with reset values; no o_done pulse.
- o_mem_addr never exceeds NUM_STAGES*SIZE_STAGE-1; the address register holds its last value when not reading.

Test Plan:
Common setup unless stated: NUM_STAGES=2, NUM_CLASSIFIERS_STAGE=2, NUM_PARAM_PER_CLASSIFIER=3, NUM_STAGE_THRESHOLD=1 (SIZE_STAGE=7); memory word = addr+100.
1. Ready tied high, both verdicts pass:
   - 14 words 100..113 at addresses 0..13, each 3 cycles apart.
   - Stage 0 (classifier, param) sequence (0,0)(0,1)(0,2)(1,0)(1,1)(1,2)(2,0); o_is_threshold only on word 106.
   - o_end_classifier on 102, 105 (and 109, 112 in stage 1); o_end_stage on 106 and 113.
   - o_done pulse; o_face_detected=1.
2. Stage 0 verdict fail:
   - Exactly 7 words, no reads at addresses ≥7.
   - o_done; o_face_detected=0.
3. Ready backpressure (i_data_ready low 5 cycles on word 103):
   - o_data=103 and indices held stable; no o_mem_ren during the stall.
   - Sequence resumes with 104.
4. Verdict delayed 10 cycles after stage 0 end:
   - No memory reads during the delay.
   - Stage 1 starts at address 7 with o_index_stage=1.
5. Reset asserted while OUT on word 104:
   - Next cycle all outputs 0, state IDLE, no o_done.
   - A new i_start restarts from address 0.
6. i_start pulsed while busy, and i_stage_result_valid pulsed during words:
   - Both ignored; sequence and result identical to scenario 1.
